// File: rtl/cache_pkg.sv
// cache_pkg: shared state encoding, default geometry and small helpers for the data cache.
package cache_pkg;

   localparam int WORD_W         = 32;
   localparam int DEF_NUM_SETS   = 16;
   localparam int DEF_LINE_WORDS = 4;
   localparam int DEF_ADDR_W     = 32;
   localparam int LINE_BITS      = WORD_W * DEF_LINE_WORDS;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      COMPARE   = 2'd1,
      WRITEBACK = 2'd2,
      ALLOCATE  = 2'd3
   } state_t;

   // Tag width left over once word-select, offset and index bits are removed.
   function automatic int tag_width(input int addr_w, input int num_sets, input int line_words);
      return addr_w - $clog2(num_sets) - $clog2(line_words) - 2;
   endfunction

   // Counters stick at all-ones instead of wrapping.
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/cache_line_array.sv
// cache_line_array: per-set tag/valid/dirty/data storage. Lookups read combinationally by index;
// updates are a full-line fill, a single-word store, or a dirty-bit clean after write-back.
module cache_line_array
   import cache_pkg::*;
#(
   parameter int NUM_SETS   = DEF_NUM_SETS,
   parameter int LINE_WORDS = DEF_LINE_WORDS,
   parameter int TAG_W      = 24
)(
   input  logic                             clk,
   input  logic                             reset,
   input  logic [$clog2(NUM_SETS)-1:0]      idx_i,
   output logic                             rd_valid_o,
   output logic                             rd_dirty_o,
   output logic [TAG_W-1:0]                 rd_tag_o,
   output logic [WORD_W*LINE_WORDS-1:0]     rd_line_o,
   input  logic                             fill_en_i,
   input  logic [TAG_W-1:0]                 fill_tag_i,
   input  logic [WORD_W*LINE_WORDS-1:0]     fill_line_i,
   input  logic                             word_en_i,
   input  logic [$clog2(LINE_WORDS)-1:0]    word_off_i,
   input  logic [WORD_W-1:0]                word_data_i,
   input  logic                             clean_en_i
);

   logic [NUM_SETS-1:0] valid_q;
   logic [NUM_SETS-1:0] dirty_q;
   logic [TAG_W-1:0]    tag_mem  [NUM_SETS];
   logic [WORD_W-1:0]   data_mem [NUM_SETS][LINE_WORDS];

   assign rd_valid_o = valid_q[idx_i];
   assign rd_dirty_o = dirty_q[idx_i];
   assign rd_tag_o   = tag_mem[idx_i];

   for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_rd_line
      assign rd_line_o[gi*WORD_W +: WORD_W] = data_mem[idx_i][gi];
   end

   // Status bits: cleared by reset, fill makes a line valid and clean, store dirties it, write-back cleans it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (fill_en_i) begin
         valid_q[idx_i] <= 1'b1;
         dirty_q[idx_i] <= 1'b0;
      end else if (word_en_i) begin
         dirty_q[idx_i] <= 1'b1;
      end else if (clean_en_i) begin
         dirty_q[idx_i] <= 1'b0;
      end
   end

   // Tag and data payload; meaningless until the valid bit qualifies them, so no reset
   always_ff @(posedge clk) begin
      if (fill_en_i) begin
         tag_mem[idx_i] <= fill_tag_i;
         for (int w = 0; w < LINE_WORDS; w++) begin
            data_mem[idx_i][w] <= fill_line_i[w*WORD_W +: WORD_W];
         end
      end else if (word_en_i) begin
         data_mem[idx_i][word_off_i] <= word_data_i;
      end
   end

endmodule

// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-back, write-allocate data cache between the MEM stage and a
// line-granular memory. One request in flight; hit and first-lookup-miss counters saturate.
module data_cache
   import cache_pkg::*;
#(
   parameter int NUM_SETS   = DEF_NUM_SETS,
   parameter int LINE_WORDS = DEF_LINE_WORDS,
   parameter int ADDR_W     = DEF_ADDR_W
)(
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          is_input_valid,
   input  logic [ADDR_W-1:0]             addr,
   input  logic                          mem_read,
   input  logic                          mem_write,
   input  logic [31:0]                   din,
   output logic                          is_ready,
   output logic                          is_output_valid,
   output logic [31:0]                   dout,
   output logic                          is_hit,
   output logic                          mem_req_valid,
   input  logic                          mem_req_ready,
   output logic                          mem_req_write,
   output logic [ADDR_W-1:0]             mem_req_addr,
   output logic [32*LINE_WORDS-1:0]      mem_req_data,
   input  logic                          mem_resp_valid,
   input  logic [32*LINE_WORDS-1:0]      mem_resp_data,
   output logic [31:0]                   hit_count,
   output logic [31:0]                   miss_count
);

   localparam int IDX_W = $clog2(NUM_SETS);
   localparam int OFF_W = $clog2(LINE_WORDS);
   localparam int TAG_W = tag_width(ADDR_W, NUM_SETS, LINE_WORDS);
   localparam int LBITS = WORD_W * LINE_WORDS;

   state_t              state_q;
   logic [ADDR_W-1:2]   addr_q;
   logic [31:0]         din_q;
   logic                store_q;
   logic                first_q;
   logic                ready_q, out_valid_q, hit_q;
   logic [31:0]         dout_q, hit_cnt_q, miss_cnt_q;
   logic                req_valid_q, req_write_q;
   logic [ADDR_W-1:0]   req_addr_q;
   logic [LBITS-1:0]    req_data_q;

   logic [OFF_W-1:0]    off;
   logic [IDX_W-1:0]    idx;
   logic [TAG_W-1:0]    tag;
   logic [ADDR_W-1:0]   line_addr, victim_addr;
   logic                rd_valid, rd_dirty;
   logic [TAG_W-1:0]    rd_tag;
   logic [LBITS-1:0]    rd_line;
   logic [WORD_W-1:0]   rd_words [LINE_WORDS];
   logic                lookup_hit, fill_fire, word_en, clean_en;
   logic                unused_addr_bits;

   // Byte-select bits never matter for word accesses.
   assign unused_addr_bits = ^addr[1:0];

   assign off         = addr_q[OFF_W+1:2];
   assign idx         = addr_q[IDX_W+OFF_W+1:OFF_W+2];
   assign tag         = addr_q[ADDR_W-1:IDX_W+OFF_W+2];
   assign line_addr   = {addr_q[ADDR_W-1:OFF_W+2], {(OFF_W+2){1'b0}}};
   assign victim_addr = {rd_tag, idx, {(OFF_W+2){1'b0}}};

   for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_words
      assign rd_words[gi] = rd_line[gi*WORD_W +: WORD_W];
   end

   // The fill may land in the same cycle the read request is accepted (zero-wait memory).
   assign lookup_hit = (state_q == COMPARE) && rd_valid && (rd_tag == tag);
   assign fill_fire  = (state_q == ALLOCATE) && mem_resp_valid && (!req_valid_q || mem_req_ready);
   assign word_en    = lookup_hit && store_q;
   assign clean_en   = (state_q == WRITEBACK) && req_valid_q && mem_req_ready;

   cache_line_array #(
      .NUM_SETS   (NUM_SETS),
      .LINE_WORDS (LINE_WORDS),
      .TAG_W      (TAG_W)
   ) u_lines (
      .clk         (clk),
      .reset       (reset),
      .idx_i       (idx),
      .rd_valid_o  (rd_valid),
      .rd_dirty_o  (rd_dirty),
      .rd_tag_o    (rd_tag),
      .rd_line_o   (rd_line),
      .fill_en_i   (fill_fire),
      .fill_tag_i  (tag),
      .fill_line_i (mem_resp_data),
      .word_en_i   (word_en),
      .word_off_i  (off),
      .word_data_i (din_q),
      .clean_en_i  (clean_en)
   );

   // Request FSM: latch, lookup, optional victim write-back, line fill, then re-lookup
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         din_q       <= '0;
         store_q     <= 1'b0;
         first_q     <= 1'b0;
         ready_q     <= 1'b1;
         out_valid_q <= 1'b0;
         hit_q       <= 1'b0;
         dout_q      <= '0;
         hit_cnt_q   <= '0;
         miss_cnt_q  <= '0;
         req_valid_q <= 1'b0;
         req_write_q <= 1'b0;
         req_addr_q  <= '0;
         req_data_q  <= '0;
      end else begin
         out_valid_q <= 1'b0;
         hit_q       <= 1'b0;
         case (state_q)
            IDLE: begin
               if (is_input_valid && (mem_read || mem_write)) begin
                  addr_q  <= addr[ADDR_W-1:2];
                  din_q   <= din;
                  store_q <= mem_write;
                  first_q <= 1'b1;
                  ready_q <= 1'b0;
                  state_q <= COMPARE;
               end
            end
            COMPARE: begin
               if (lookup_hit) begin
                  if (!store_q) begin
                     dout_q <= rd_words[off];
                  end
                  out_valid_q <= 1'b1;
                  hit_q       <= first_q;
                  if (first_q) begin
                     hit_cnt_q <= sat_inc(hit_cnt_q);
                  end
                  ready_q <= 1'b1;
                  state_q <= IDLE;
               end else begin
                  first_q <= 1'b0;
                  if (first_q) begin
                     miss_cnt_q <= sat_inc(miss_cnt_q);
                  end
                  req_valid_q <= 1'b1;
                  if (rd_valid && rd_dirty) begin
                     req_write_q <= 1'b1;
                     req_addr_q  <= victim_addr;
                     req_data_q  <= rd_line;
                     state_q     <= WRITEBACK;
                  end else begin
                     req_write_q <= 1'b0;
                     req_addr_q  <= line_addr;
                     state_q     <= ALLOCATE;
                  end
               end
            end
            WRITEBACK: begin
               if (mem_req_ready) begin
                  req_write_q <= 1'b0;
                  req_addr_q  <= line_addr;
                  state_q     <= ALLOCATE;
               end
            end
            ALLOCATE: begin
               if (req_valid_q && mem_req_ready) begin
                  req_valid_q <= 1'b0;
               end
               if (fill_fire) begin
                  state_q <= COMPARE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign is_ready        = ready_q;
   assign is_output_valid = out_valid_q;
   assign dout            = dout_q;
   assign is_hit          = hit_q;
   assign mem_req_valid   = req_valid_q;
   assign mem_req_write   = req_write_q;
   assign mem_req_addr    = req_addr_q;
   assign mem_req_data    = req_data_q;
   assign hit_count       = hit_cnt_q;
   assign miss_count      = miss_cnt_q;

endmodule
